multicycle_ctrl: RTL and testbench

Moore-style multicycle control unit that sequences the shared datapath: ALU, PC, IR, register file and unified memory port. Each instruction is stepped through fetch, decode, execute, memory and writeback. The unit drives the 2-bit ALUop, operand-select muxes and write enables. It also handles the memory ready handshake with a wait-timeout, and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'h33;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'h13;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;

    localparam logic IORD_PC       = 1'b0;
    localparam logic IORD_ALUOUT   = 1'b1;
    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory signal bundle.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import ctrl_pkg::*;

    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                is_zero;
    logic                mem_ready;
    logic [1:0]          alu_op;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                pc_src;
    logic                reg_write;
    logic [1:0]          wb_sel;
    logic                illegal;
    logic                bus_error;
    logic                busy;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  run, opcode, is_zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, pc_src, reg_write, wb_sel,
               illegal, bus_error, busy, retired
    );

    modport slave (
        output run, opcode, is_zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
               ir_write, pc_write, pc_write_cond, pc_src, reg_write, wb_sel,
               illegal, bus_error, busy, retired
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; expired flags the last allowed wait cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Wait-cycle counter; clear has priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore multicycle sequencer for the shared ALU/PC/IR/regfile/memory datapath.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    state_t           state;
    logic [CNT_W-1:0] retired_q;
    logic             bus_error_q;
    logic             in_wait;
    logic             expired;
    logic             timeout;
    logic             retire;

    logic [1:0] alu_op, src_a, src_b, wb_sel;
    logic       iord, mem_read, mem_write, ir_write, pc_write;
    logic       pc_write_cond, pc_src, reg_write, illegal;

    // Memory states are always left on mem_ready, so clearing on it re-arms the timer on entry.
    assign in_wait = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign timeout = in_wait && !bus.mem_ready && expired;
    assign retire  = (state inside {S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL}) ||
                     ((state == S_MEM_WR) && bus.mem_ready);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait || bus.mem_ready),
        .enable  (in_wait && !bus.mem_ready),
        .expired (expired)
    );

    // State sequencing, retire counter and sticky bus error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else if (timeout) begin
            state       <= S_FAULT;
            bus_error_q <= 1'b1;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
            state     <= bus.run ? S_FETCH : S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (bus.run) state <= S_FETCH;
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_R:               state <= S_EXEC_R;
                        OP_I:               state <= S_EXEC_I;
                        OP_LOAD, OP_STORE:  state <= S_MEM_ADDR;
                        OP_BRANCH:          state <= S_BRANCH;
                        OP_JAL:             state <= S_JAL;
                        default:            state <= bus.run ? S_FETCH : S_IDLE;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state <= S_ALU_WB;
                S_MEM_ADDR: state <= (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WR, S_FAULT: state <= state;
                default:    state <= S_IDLE;
            endcase
        end
    end

    // Per-state control decode; only ir_write/pc_write in FETCH look at mem_ready.
    always_comb begin
        alu_op        = ALU_ADD;
        src_a         = SRC_A_PC;
        src_b         = SRC_B_REG;
        wb_sel        = WB_ALUOUT;
        iord          = IORD_PC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = SRC_B_FOUR;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
            end
            S_DECODE: begin
                src_a   = SRC_A_OLD_PC;
                src_b   = SRC_B_IMM;
                illegal = !op_is_legal(bus.opcode);
            end
            S_EXEC_R: begin
                src_a  = SRC_A_REG;
                alu_op = ALU_FUNCT;
            end
            S_EXEC_I: begin
                src_a  = SRC_A_REG;
                src_b  = SRC_B_IMM;
                alu_op = ALU_FUNCT;
            end
            S_ALU_WB:   reg_write = 1'b1;
            S_MEM_ADDR: begin
                src_a = SRC_A_REG;
                src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = IORD_ALUOUT;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = IORD_ALUOUT;
            end
            S_BRANCH: begin
                src_a         = SRC_A_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_LINK;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_ALUOUT;
            end
            default: ;
        endcase
    end

    assign bus.alu_op        = alu_op;
    assign bus.alu_src_a     = src_a;
    assign bus.alu_src_b     = src_b;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_src        = pc_src;
    assign bus.reg_write     = reg_write;
    assign bus.wb_sel        = wb_sel;
    assign bus.illegal       = illegal;
    assign bus.bus_error     = bus_error_q;
    assign bus.busy          = !(state inside {S_IDLE, S_FAULT});
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a per-step expected-output model.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO   = 4;

    typedef struct packed {
        logic [1:0]       alu_op;
        logic [1:0]       src_a;
        logic [1:0]       src_b;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             pc_write;
        logic             pc_write_cond;
        logic             pc_src;
        logic             reg_write;
        logic [1:0]       wb_sel;
        logic             illegal;
        logic             bus_error;
        logic             busy;
        logic             pc_load;
        logic [CNT_W-1:0] retired;
    } outs_t;

    logic clk;
    logic rst;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_cmp;
    int               n_bad;
    outs_t            exp_o;
    outs_t            act_o;
    logic             exp_valid;
    string            step_name;
    logic [CNT_W-1:0] model_retired;
    logic             model_idle;

    // Expected output vectors, one per instruction step, straight from the control table.
    function automatic outs_t v_zero();
        outs_t e = '0;
        return e;
    endfunction

    function automatic outs_t v_busy();
        outs_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic outs_t v_fetch(input logic ready);
        outs_t e = v_busy();
        e.mem_read = 1'b1;
        e.src_b    = 2'b01;
        e.ir_write = ready;
        e.pc_write = ready;
        e.pc_load  = ready;
        return e;
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) ||
               (op == 7'h23) || (op == 7'h63) || (op == 7'h6F);
    endfunction

    function automatic outs_t v_decode(input logic [6:0] op);
        outs_t e = v_busy();
        e.src_a   = 2'b10;
        e.src_b   = 2'b10;
        e.illegal = !known_op(op);
        return e;
    endfunction

    function automatic outs_t v_alu(input logic imm);
        outs_t e = v_busy();
        e.src_a  = 2'b01;
        e.src_b  = imm ? 2'b10 : 2'b00;
        e.alu_op = 2'b10;
        return e;
    endfunction

    function automatic outs_t v_wb(input logic [1:0] sel);
        outs_t e = v_busy();
        e.reg_write = 1'b1;
        e.wb_sel    = sel;
        return e;
    endfunction

    function automatic outs_t v_addr();
        outs_t e = v_busy();
        e.src_a = 2'b01;
        e.src_b = 2'b10;
        return e;
    endfunction

    function automatic outs_t v_mem(input logic wr);
        outs_t e = v_busy();
        e.iord      = 1'b1;
        e.mem_read  = !wr;
        e.mem_write = wr;
        return e;
    endfunction

    function automatic outs_t v_branch(input logic z);
        outs_t e = v_busy();
        e.src_a         = 2'b01;
        e.alu_op        = 2'b01;
        e.pc_write_cond = 1'b1;
        e.pc_src        = 1'b1;
        e.pc_load       = z;
        return e;
    endfunction

    function automatic outs_t v_jal();
        outs_t e = v_wb(2'b10);
        e.pc_write = 1'b1;
        e.pc_src   = 1'b1;
        e.pc_load  = 1'b1;
        return e;
    endfunction

    function automatic outs_t v_fault();
        outs_t e = '0;
        e.bus_error = 1'b1;
        return e;
    endfunction

    // Publish one cycle's expectation, let it be checked, advance to just after the next edge.
    task automatic tick(input string name, input outs_t e);
        e.retired = model_retired;
        step_name = name;
        exp_o     = e;
        exp_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Drive one instruction through; run_next is the run level seen at its retire/illegal cycle.
    task automatic do_instr(input logic [6:0] op, input int fwait, input int mwait,
                            input logic z, input logic run_next);
        bus.run = 1'b1;
        if (model_idle) begin
            tick("idle_go", v_zero());
            model_idle = 1'b0;
        end
        bus.opcode  = op;
        bus.is_zero = z;
        for (int i = 0; i < fwait; i++) begin
            bus.mem_ready = 1'b0;
            tick("fetch_wait", v_fetch(1'b0));
        end
        bus.mem_ready = 1'b1;
        tick("fetch", v_fetch(1'b1));
        if (!known_op(op)) begin
            bus.run = run_next;
            tick("decode_illegal", v_decode(op));
            model_idle = !run_next;
            return;
        end
        tick("decode", v_decode(op));
        case (op)
            7'h33, 7'h13: begin
                tick("exec", v_alu(op == 7'h13));
                bus.run = run_next;
                tick("alu_wb", v_wb(2'b00));
            end
            7'h03: begin
                tick("mem_addr", v_addr());
                for (int i = 0; i < mwait; i++) begin
                    bus.mem_ready = 1'b0;
                    tick("mem_rd_wait", v_mem(1'b0));
                end
                bus.mem_ready = 1'b1;
                tick("mem_rd", v_mem(1'b0));
                bus.run = run_next;
                tick("mem_wb", v_wb(2'b01));
            end
            7'h23: begin
                tick("mem_addr", v_addr());
                for (int i = 0; i < mwait; i++) begin
                    bus.mem_ready = 1'b0;
                    tick("mem_wr_wait", v_mem(1'b1));
                end
                bus.mem_ready = 1'b1;
                bus.run = run_next;
                tick("mem_wr", v_mem(1'b1));
            end
            7'h63: begin
                bus.run = run_next;
                tick("branch", v_branch(z));
            end
            default: begin
                bus.run = run_next;
                tick("jal", v_jal());
            end
        endcase
        model_retired = model_retired + CNT_W'(1);
        model_idle    = !run_next;
    endtask

    // Single compare point for every published expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            act_o.alu_op        = bus.alu_op;
            act_o.src_a         = bus.alu_src_a;
            act_o.src_b         = bus.alu_src_b;
            act_o.iord          = bus.iord;
            act_o.mem_read      = bus.mem_read;
            act_o.mem_write     = bus.mem_write;
            act_o.ir_write      = bus.ir_write;
            act_o.pc_write      = bus.pc_write;
            act_o.pc_write_cond = bus.pc_write_cond;
            act_o.pc_src        = bus.pc_src;
            act_o.reg_write     = bus.reg_write;
            act_o.wb_sel        = bus.wb_sel;
            act_o.illegal       = bus.illegal;
            act_o.bus_error     = bus.bus_error;
            act_o.busy          = bus.busy;
            act_o.pc_load       = bus.pc_write | (bus.pc_write_cond & bus.is_zero);
            act_o.retired       = bus.retired;
            n_cmp++;
            if (act_o !== exp_o) begin
                n_bad++;
                $display("FAIL outputs[%s] @%0t got=%h want=%h", step_name, $time, act_o, exp_o);
            end
        end
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        exp_valid     = 1'b0;
        exp_o         = '0;
        step_name     = "none";
        model_retired = '0;
        model_idle    = 1'b1;
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.opcode    = '0;
        bus.is_zero   = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        tick("reset", v_zero());
        tick("reset", v_zero());
        rst = 1'b0;
        tick("idle", v_zero());
        tick("idle", v_zero());

        // Normal instruction mix with run held high.
        do_instr(7'h33, 0, 0, 1'b0, 1'b1);
        check_lit("retired_after_r", 32'(bus.retired), 32'd1);
        do_instr(7'h13, 0, 0, 1'b0, 1'b1);
        do_instr(7'h03, 0, 3, 1'b0, 1'b1);
        do_instr(7'h23, 0, 1, 1'b0, 1'b1);
        do_instr(7'h63, 0, 0, 1'b1, 1'b1);
        do_instr(7'h63, 0, 0, 1'b0, 1'b1);
        do_instr(7'h6F, 0, 0, 1'b0, 1'b1);
        do_instr(7'h7F, 0, 0, 1'b0, 1'b1);
        check_lit("retired_after_illegal", 32'(bus.retired), 32'd7);
        do_instr(7'h33, 2, 0, 1'b0, 1'b1);

        // run dropped at a retire parks the unit in IDLE.
        do_instr(7'h33, 0, 0, 1'b0, 1'b0);
        bus.run = 1'b0;
        tick("idle_parked", v_zero());
        tick("idle_parked", v_zero());
        check_lit("busy_parked", 32'(bus.busy), 32'd0);

        // Counter wrap: 9 + 9 retirements wrap a 4-bit counter to 2.
        for (int i = 0; i < 9; i++) do_instr(7'h33, 0, 0, 1'b0, 1'b1);
        check_lit("retired_wrap", 32'(bus.retired), 32'd2);

        // Async reset in the middle of a stalled store.
        bus.opcode = 7'h23;
        bus.mem_ready = 1'b1;
        tick("fetch", v_fetch(1'b1));
        tick("decode", v_decode(7'h23));
        tick("mem_addr", v_addr());
        bus.mem_ready = 1'b0;
        tick("mem_wr_wait", v_mem(1'b1));
        tick("mem_wr_wait", v_mem(1'b1));
        rst = 1'b1;
        model_retired = '0;
        tick("reset_mid_store", v_zero());
        tick("reset_mid_store", v_zero());
        rst = 1'b0;
        bus.run = 1'b0;
        model_idle = 1'b1;
        tick("idle_after_reset", v_zero());

        // Fetch that never completes faults after TMO cycles and stays faulted.
        bus.run = 1'b1;
        tick("idle_go", v_zero());
        bus.opcode = 7'h33;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) tick("fetch_stall", v_fetch(1'b0));
        tick("fault", v_fault());
        bus.mem_ready = 1'b1;
        tick("fault_sticky", v_fault());
        tick("fault_sticky", v_fault());
        check_lit("bus_error_sticky", 32'(bus.bus_error), 32'd1);
        check_lit("busy_fault", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        tick("reset_from_fault", v_zero());
        rst = 1'b0;
        bus.run = 1'b0;
        tick("idle_after_fault", v_zero());
        model_idle = 1'b1;

        // Back to normal operation after recovering from the fault.
        do_instr(7'h6F, 0, 0, 1'b0, 1'b0);
        bus.run = 1'b0;
        tick("idle_end", v_zero());
        check_lit("retired_end", 32'(bus.retired), 32'd1);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
